prime_check_scheduler: RTL and testbench

Shares one iterative trial-division prime checker between `N_REQ` requesters. Arbitrates incoming candidate numbers round-robin and sequences the checker one divisor per cycle. Returns each verdict with the requester's ID over a valid/ready response port. Sits in front of the prime-search datapath so several producers can issue 11-bit candidates without each owning a checker.

---
 rtl/prime_sched_pkg.sv | 23 ++
 rtl/prime_trial_core.sv | 62 ++++++
 rtl/prime_check_scheduler.sv | 169 ++++++++++++++++
 tb/tb_prime_check_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_sched_pkg.sv
// rtl/prime_sched_pkg.sv - shared types, defaults and width helpers for the prime check scheduler
package prime_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } sched_state_e;

    localparam int DATA_W_DEF = 11;

    function automatic int id_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // Divisor never exceeds floor(sqrt(n))+1, which fits in ceil(w/2)+1 bits
    function automatic int div_width(input int data_w);
        return (data_w + 1) / 2 + 1;
    endfunction

    localparam int DIV_W_DEF = div_width(DATA_W_DEF);

endpackage

// File: rtl/prime_trial_core.sv
// rtl/prime_trial_core.sv - iterative trial-division checker, one divisor per cycle
module prime_trial_core
    import prime_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic              done,
    output logic              is_prime
);

    localparam int DW = div_width(DATA_W);
    localparam int PW = 2 * DW;

    logic [DW-1:0] d_q, d_d;
    logic          active_q, active_d;
    logic [PW-1:0] n_ext, d_ext, d_sq, n_rem;
    logic          lt_two, sq_gt, divides;

    // Square and remainder at double divisor width so d*d cannot wrap
    always_comb begin
        n_ext   = PW'(n);
        d_ext   = PW'(d_q);
        d_sq    = d_ext * d_ext;
        n_rem   = n_ext % d_ext;
        lt_two  = (n_ext < PW'(2));
        sq_gt   = (d_sq > n_ext);
        divides = (n_rem == '0);
    end

    assign done     = active_q & (lt_two | sq_gt | divides);
    assign is_prime = ~lt_two & sq_gt;

    always_comb begin
        d_d      = d_q;
        active_d = active_q;
        if (start) begin
            d_d      = DW'(2);
            active_d = 1'b1;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
            end else begin
                d_d = d_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= DW'(2);
            active_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/prime_check_scheduler.sv
// rtl/prime_check_scheduler.sv - round-robin front end sharing one prime checker; PRIME_STATS_EN adds prime_count
module prime_check_scheduler
    import prime_sched_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  N_REQ  = 2,
    localparam int ID_W   = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_num,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_num,
    output logic                    rsp_prime,
    output logic                    busy,
    output logic [DATA_W-1:0]       prime_count
);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_num_q, rsp_num_d;
    logic              rsp_prime_q, rsp_prime_d;
    logic              busy_q, busy_d;

    logic              hi_found, lo_found, grant_found;
    logic [ID_W-1:0]   hi_id, lo_id, grant_id;
    logic [DATA_W-1:0] grant_num;
    logic              handshake;
    logic              core_start, core_done, core_prime;

    // First valid at or above rr_ptr wins; otherwise wrap to the lowest valid
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        req_ready = '0;
        grant_num = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                grant_num    = req_num[i*DATA_W +: DATA_W];
                req_ready[i] = (state_q == ST_IDLE) & ~rst & grant_found;
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    prime_trial_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (core_start),
        .n       (num_q),
        .done    (core_done),
        .is_prime(core_prime)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        num_d       = num_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_num_d   = rsp_num_q;
        rsp_prime_d = rsp_prime_q;
        core_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    num_d      = grant_num;
                    id_d       = grant_id;
                    rr_ptr_d   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    core_start = 1'b1;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (core_done) begin
                    rsp_num_d   = num_q;
                    rsp_id_d    = id_q;
                    rsp_prime_d = core_prime;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            num_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_num_q   <= '0;
            rsp_prime_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            num_q       <= num_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_num_q   <= rsp_num_d;
            rsp_prime_q <= rsp_prime_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_num   = rsp_num_q;
    assign rsp_prime = rsp_prime_q;
    assign busy      = busy_q;

`ifdef PRIME_STATS_EN
    logic [DATA_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (rsp_valid_q && rsp_ready && rsp_prime_q && (count_q != '1)) begin
            count_q <= count_q + DATA_W'(1);
        end
    end

    assign prime_count = count_q;
`else
    assign prime_count = '0;
`endif

endmodule

// File: tb/tb_prime_check_scheduler.sv
// tb/tb_prime_check_scheduler.sv - scoreboard bench for prime_check_scheduler
module tb_prime_check_scheduler;

    localparam int DW = 11;
    localparam int NR = 2;
    localparam int IW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_num;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_num;
    logic             rsp_prime;
    logic             busy;
    logic [DW-1:0]    prime_count;

    prime_check_scheduler #(
        .DATA_W(DW),
        .N_REQ (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_num    (req_num),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_num    (rsp_num),
        .rsp_prime  (rsp_prime),
        .busy       (busy),
        .prime_count(prime_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int num;
        int prime;
        int acc;
        int c;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    bit   in_rsp      = 1'b0;
    bit   expect_idle = 1'b0;
    int   exp_count   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_prime(input int n);
        int p;
        p = (n >= 2) ? 1 : 0;
        for (int k = 2; k < n; k++) if (n % k == 0) p = 0;
        return p;
    endfunction

    function automatic int model_c(input int n);
        if (n < 2) return 1;
        for (int d = 2; d <= n + 1; d++) begin
            if (d * d > n || n % d == 0) return d - 1;
        end
        return 0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            in_rsp      = 1'b0;
            expect_idle = 1'b0;
            exp_count   = 0;
        end else begin
            check_eq("prime_count", int'(prime_count), exp_count);
            if (expect_idle) begin
                check_eq("idle_after_rsp", int'(busy), 0);
                expect_idle = 1'b0;
            end
            if (busy) check_eq("ready_while_busy", int'(req_ready), 0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_rsp", int'(sb.size()), 1);
                end else begin
                    e = sb[0];
                    if (!in_rsp) begin
                        check_eq("latency", cyc - e.acc, e.c + 1);
                        in_rsp = 1'b1;
                    end
                    check_eq("rsp_id", int'(rsp_id), e.id);
                    check_eq("rsp_num", int'(rsp_num), e.num);
                    check_eq("rsp_prime", int'(rsp_prime), e.prime);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        in_rsp      = 1'b0;
                        expect_idle = 1'b1;
`ifdef PRIME_STATS_EN
                        if (e.prime != 0 && exp_count < (1 << DW) - 1) exp_count++;
`endif
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id    = i;
                    e.num   = int'(req_num[i*DW +: DW]);
                    e.prime = model_prime(e.num);
                    e.c     = model_c(e.num);
                    e.acc   = cyc;
                    sb.push_back(e);
                    gq.push_back(i);
                end
            end
        end
    end

    task automatic send(input int id, input int n);
        bit got;
        @(posedge clk);
        #1;
        req_valid[id]          = 1'b1;
        req_num[id*DW +: DW]   = n[DW-1:0];
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        check_eq("tmo_grant", int'(got), 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        check_eq("tmo_done", int'(ok), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        gq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t2[4];
        bit  ok;
        rst       = 1'b1;
        req_valid = '0;
        req_num   = '0;
        rsp_ready = 1'b1;

        // Reset state and no grant while rst is high
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("ready_in_rst", int'(req_ready), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_rsp_num", int'(rsp_num), 0);
        check_eq("rst_rsp_prime", int'(rsp_prime), 0);

        // Single query
        send(0, 7);
        wait_done();

        // Edge values
        t2 = '{0, 1, 2, 4};
        foreach (t2[j]) begin
            send(0, t2[j]);
            wait_done();
        end

        // Contention from reset, then continuous requests
        do_reset();
        #1;
        req_num   = {DW'(11), DW'(9)};
        req_valid = 2'b11;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (gq.size() >= 3) ok = 1'b1;
        end
        check_eq("tmo_rr", int'(ok), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        check_eq("rr_g0", gq[0], 0);
        check_eq("rr_g1", gq[1], 1);
        check_eq("rr_g2", gq[2], 0);
        wait_done();

        // Backpressure with a pending request from the other requester
        rsp_ready = 1'b0;
        send(0, 97);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        check_eq("tmo_rsp97", int'(ok), 1);
        @(posedge clk);
        #1;
        req_valid[1]       = 1'b1;
        req_num[DW +: DW]  = DW'(5);
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_done();
        check_eq("bp_grant_req1", gq[gq.size()-1], 1);

        // Reset in the middle of a long check
        send(0, 2039);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", int'(rsp_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_id", int'(rsp_id), 0);
        check_eq("mid_rst_num", int'(rsp_num), 0);
        check_eq("mid_rst_prime", int'(rsp_prime), 0);
        check_eq("mid_rst_count", int'(prime_count), 0);
        check_eq("mid_rst_ready", int'(req_ready), 0);
        send(0, 5);
        wait_done();

        // Sweep 0..100
        do_reset();
        for (int n = 0; n <= 100; n++) send(0, n);
        wait_done();
`ifdef PRIME_STATS_EN
        check_eq("sweep_count", int'(prime_count), 25);
`else
        check_eq("sweep_count", int'(prime_count), 0);
`endif
        check_eq("sb_empty", int'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
